// File: rtl/spi_stream_pkg.sv
// Shared types and sizing helpers for the serial stream transmitter.
package spi_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam int unsigned DEFAULT_PACKET_LENGTH = 32;

  // Bit counter width; a 1-bit packet still needs a 1-bit counter.
  function automatic int unsigned bit_cnt_width(input int unsigned packet_length);
    return (packet_length > 1) ? $clog2(packet_length) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy level.
module spi_tx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       sclk,
  input  logic                       aresetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_c, do_pop_c;

  // Refused pushes and pops are dropped here so callers need no gating.
  assign do_push_c = push_i && !full_q;
  assign do_pop_c  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(do_push_c) - LVL_W'(do_pop_c);
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge sclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/spi_stream_tx.sv
// Buffered MSB-first serializer with an enforced inter-packet idle gap.
// Optional packet counter output enabled by defining SPI_TX_PKT_CNT_EN.
module spi_stream_tx
  import spi_stream_pkg::*;
#(
  parameter int unsigned PACKET_LENGTH = DEFAULT_PACKET_LENGTH,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned GAP_CYCLES    = 8
) (
  input  logic                          sclk,
  input  logic                          aresetn,
  input  logic [PACKET_LENGTH-1:0]      in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          sdata,
  output logic                          svalid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SPI_TX_PKT_CNT_EN
  ,
  output logic [15:0]                   pkt_count
`endif
);

  localparam int unsigned BIT_W = bit_cnt_width(PACKET_LENGTH);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tx_state_e                state_q, state_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic [PACKET_LENGTH-1:0] shift_q, shift_d;
  logic                     sdata_q, sdata_d;
  logic                     svalid_q, svalid_d;
  logic                     load_c;
`ifdef SPI_TX_PKT_CNT_EN
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;
`endif

  logic [PACKET_LENGTH-1:0] fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;

  spi_tx_fifo #(
    .WIDTH (PACKET_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sclk      (sclk),
    .aresetn   (aresetn),
    .push_i    (in_valid),
    .wr_data_i (in_data),
    .pop_i     (load_c),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // Next-state and datapath; a load from IDLE or end-of-GAP shares one path.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    sdata_d   = sdata_q;
    svalid_d  = svalid_q;
    load_c    = 1'b0;
`ifdef SPI_TX_PKT_CNT_EN
    pkt_cnt_d = pkt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) load_c = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt_q == BIT_W'(PACKET_LENGTH - 1)) begin
          svalid_d  = 1'b0;
          sdata_d   = 1'b0;
          gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          state_d   = GAP;
`ifdef SPI_TX_PKT_CNT_EN
          pkt_cnt_d = pkt_cnt_q + 16'd1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          sdata_d   = shift_q[PACKET_LENGTH-1];
          shift_d   = shift_q << 1;
        end
      end
      GAP: begin
        if (gap_cnt_q != '0)  gap_cnt_d = gap_cnt_q - GAP_W'(1);
        else if (!fifo_empty) load_c    = 1'b1;
        else                  state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // shift_q holds the bits still to send, already aligned to the MSB.
    if (load_c) begin
      shift_d   = fifo_head << 1;
      bit_cnt_d = '0;
      svalid_d  = 1'b1;
      sdata_d   = fifo_head[PACKET_LENGTH-1];
      state_d   = SHIFT;
    end
  end

  always_ff @(posedge sclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      sdata_q   <= 1'b0;
      svalid_q  <= 1'b0;
`ifdef SPI_TX_PKT_CNT_EN
      pkt_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      sdata_q   <= sdata_d;
      svalid_q  <= svalid_d;
`ifdef SPI_TX_PKT_CNT_EN
      pkt_cnt_q <= pkt_cnt_d;
`endif
    end
  end

  assign sdata    = sdata_q;
  assign svalid   = svalid_q;
  assign in_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;
`ifdef SPI_TX_PKT_CNT_EN
  assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_spi_stream_tx.sv
// Self-checking bench for spi_stream_tx: vector table, scoreboard, corner sequences.
module tb_spi_stream_tx;

  localparam int unsigned PL = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned GC = 8;

  logic        sclk = 1'b0;
  logic        aresetn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        sdata;
  logic        svalid;
  logic        busy;
  logic [2:0]  fifo_level;
`ifdef SPI_TX_PKT_CNT_EN
  logic [15:0] pkt_count;
  logic [15:0] pcnt_exp;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          gaps_q[$];
  logic [31:0] sh;
  logic [31:0] ew;
  int          nbits = 0;
  int          low_run = 0;
  bit          seen_pkt = 1'b0;
  int          words_rx = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_word;
    logic        exp_msb;
  } vec_t;
  vec_t vecs[5];

  spi_stream_tx #(
    .PACKET_LENGTH (PL),
    .FIFO_DEPTH    (FD),
    .GAP_CYCLES    (GC)
  ) dut (
    .sclk       (sclk),
    .aresetn    (aresetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sdata      (sdata),
    .svalid     (svalid),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef SPI_TX_PKT_CNT_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Deserializer and gap monitor, sampled on the falling edge.
  always @(negedge sclk or negedge aresetn) begin
    if (!aresetn) begin
      nbits    = 0;
      low_run  = 0;
      seen_pkt = 1'b0;
    end else if (svalid) begin
      if (nbits == 0 && seen_pkt) gaps_q.push_back(low_run);
      low_run = 0;
      sh = {sh[30:0], sdata};
      nbits++;
      if (nbits == PL) begin
        nbits    = 0;
        seen_pkt = 1'b1;
        words_rx++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected none", sh);
        end else begin
          ew = exp_q.pop_front();
          check("rx_word", 64'(sh), 64'(ew));
        end
      end
    end else begin
      if (nbits != 0) begin
        check("svalid_short", 64'(nbits), 64'(PL));
        nbits = 0;
      end
      low_run++;
    end
  end

  // One clock: drive at negedge, optionally record an accepted word, return at next negedge.
  task automatic cycle(input logic v, input logic [31:0] d, input bit acc);
    in_valid = v;
    in_data  = d;
    @(posedge sclk);
    if (acc) exp_q.push_back(d);
    @(negedge sclk);
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [31:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 400) begin
      @(negedge sclk);
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready 0 expected 1");
    end else begin
      @(posedge sclk);
      exp_q.push_back(d);
    end
    @(negedge sclk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 3000) begin
      @(negedge sclk);
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending %0d expected 0", exp_q.size());
    end
  endtask

  // Single packet from idle with exact latency and svalid-width checks.
  task automatic send_single(input logic [31:0] d, input logic [31:0] expw, input logic msb,
                             input bit chk_cnt);
    cycle(1'b1, d, 1'b0);
    exp_q.push_back(expw);
    check("lat_n_svalid", 64'(svalid), 0);
    check("lat_n_level", 64'(fifo_level), 1);
    check("lat_n_busy", 64'(busy), 1);
    cycle(1'b0, '0, 1'b0);
    check("first_svalid", 64'(svalid), 1);
    check("first_sdata", 64'(sdata), 64'(msb));
    check("first_level", 64'(fifo_level), 0);
    repeat (31) cycle(1'b0, '0, 1'b0);
    check("last_svalid", 64'(svalid), 1);
`ifdef SPI_TX_PKT_CNT_EN
    if (chk_cnt) check("pkt_cnt_before", 64'(pkt_count), 64'(pcnt_exp));
`endif
    cycle(1'b0, '0, 1'b0);
    check("end_svalid", 64'(svalid), 0);
    check("end_sdata", 64'(sdata), 0);
`ifdef SPI_TX_PKT_CNT_EN
    if (chk_cnt) begin
      pcnt_exp = pcnt_exp + 16'd1;
      check("pkt_cnt_after", 64'(pkt_count), 64'(pcnt_exp));
    end
`endif
    wait_drain();
    check("idle_busy", 64'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{32'h8000_0001, 32'h8000_0001, 1'b1};
    vecs[4] = '{32'h7FFF_FFFE, 32'h7FFF_FFFE, 1'b0};

    aresetn  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge sclk);
    check("rst_sdata", 64'(sdata), 0);
    check("rst_svalid", 64'(svalid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_level", 64'(fifo_level), 0);
    check("rst_busy", 64'(busy), 0);
    aresetn = 1'b1;
    @(negedge sclk);

    // Single packets from the vector table.
    for (int i = 0; i < 5; i++) send_single(vecs[i].data, vecs[i].exp_word, vecs[i].exp_msb, 1'b0);
    check("table_words", 64'(words_rx), 5);

    // Streaming with in_valid held: fills to 4, then back-to-back packets.
    gaps_q.delete();
    for (int i = 1; i <= 5; i++) begin
      check("stream_ready", 64'(in_ready), 1);
      cycle(1'b1, 32'(i), 1'b1);
    end
    check("stream_full_level", 64'(fifo_level), 4);
    check("stream_full_ready", 64'(in_ready), 0);
    push_wait(32'h6);
    wait_drain();
    check("stream_words", 64'(words_rx), 11);
    check("stream_gap_count", 64'(gaps_q.size()), 6);
    for (int i = 1; i < 6 && i < gaps_q.size(); i++) check("stream_gap_len", 64'(gaps_q[i]), 64'(GC));

    // Push coinciding with the end-of-gap pop, then overflow refusal.
    cycle(1'b1, 32'h1111_0001, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h2222_0002, 1'b1);
    cycle(1'b1, 32'h3333_0003, 1'b1);
    cycle(1'b1, 32'h4444_0004, 1'b1);
    check("pp_level3", 64'(fifo_level), 3);
    repeat (36) cycle(1'b0, '0, 1'b0);
    check("pp_gap_svalid", 64'(svalid), 0);
    check("pp_gap_level", 64'(fifo_level), 3);
    cycle(1'b1, 32'h5555_0005, 1'b1);
    check("pp_same_edge_level", 64'(fifo_level), 3);
    check("pp_same_edge_svalid", 64'(svalid), 1);
    cycle(1'b1, 32'h6666_0006, 1'b1);
    check("pp_full_level", 64'(fifo_level), 4);
    check("pp_full_ready", 64'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hBAD0_0000 + 32'(i), 1'b0);
      check("pp_refused_level", 64'(fifo_level), 4);
    end
    wait_drain();

    // Reset mid-packet with two words queued.
    cycle(1'b1, 32'hC0DE_0001, 1'b1);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'hC0DE_0002, 1'b1);
    cycle(1'b1, 32'hC0DE_0003, 1'b1);
    check("mid_level2", 64'(fifo_level), 2);
    repeat (9) cycle(1'b0, '0, 1'b0);
    check("mid_svalid", 64'(svalid), 1);
    #2 aresetn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_svalid", 64'(svalid), 0);
    check("mid_rst_sdata", 64'(sdata), 0);
    check("mid_rst_level", 64'(fifo_level), 0);
    check("mid_rst_ready", 64'(in_ready), 1);
    @(negedge sclk);
    @(negedge sclk);
    aresetn = 1'b1;
    @(negedge sclk);
    check("post_rst_busy", 64'(busy), 0);
    send_single(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("post_rst_words", 64'(words_rx), 18);

`ifdef SPI_TX_PKT_CNT_EN
    pcnt_exp = 16'd1;
    check("cnt_after_reset_pkt", 64'(pkt_count), 64'(pcnt_exp));
    send_single(32'h0123_4567, 32'h0123_4567, 1'b0, 1'b1);
    send_single(32'h89AB_CDEF, 32'h89AB_CDEF, 1'b1, 1'b1);
    check("cnt_three", 64'(pkt_count), 3);
    force dut.pkt_cnt_q = 16'hFFFF;
    @(negedge sclk);
    release dut.pkt_cnt_q;
    @(negedge sclk);
    pcnt_exp = 16'hFFFF;
    check("cnt_forced", 64'(pkt_count), 64'hFFFF);
    send_single(32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1'b1);
    check("cnt_wrap", 64'(pkt_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
